// File: rtl/test_bridge_host.sv
// Host-side initiator for the debug test-bridge byte protocol.
// Frames sync / register-window write / register-window read commands onto a
// byte link and parses the bridge's replies into read data and status pulses.
module test_bridge_host #(
  parameter int unsigned CTimeOut = 1000,
  parameter int unsigned CWrGap   = 0
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic        ASync1K,
  input  logic        ACmdStart,
  input  logic [1:0]  ACmdOp,
  input  logic [11:0] ACmdAddr,
  input  logic [15:0] ACmdLen,
  input  logic [7:0]  AWrData,
  input  logic        AWrValid,
  output logic        AWrReady,
  output logic [7:0]  ARdData,
  output logic        ARdValid,
  output logic [7:0]  ATxData,
  output logic        ATxValid,
  input  logic        ATxReady,
  input  logic [7:0]  ARxData,
  input  logic        ARxValid,
  output logic        ABusy,
  output logic        ADone,
  output logic        AErr,
  output logic [1:0]  AErrCode,
  output logic        AAttSeen
);

  localparam int unsigned ToW = (CTimeOut > 1) ? $clog2(CTimeOut + 1) : 1;

  localparam logic [1:0] OpSync  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;

  localparam logic [1:0] ErrTimeout = 2'b01;
  localparam logic [1:0] ErrBadResp = 2'b10;
  localparam logic [1:0] ErrBadOp   = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StTxSync,
    StTxHdr,
    StSendData,
    StGap,
    StWaitSync,
    StWaitAck,
    StWaitHdr,
    StRecvData,
    StDone,
    StErr
  } stateT;

  stateT        stateQ, stateD;
  logic [1:0]   opQ, opD;
  logic [11:0]  addrQ, addrD;
  logic [15:0]  lenQ, lenD;
  logic [15:0]  remQ, remD;
  logic [1:0]   hdrIdxQ, hdrIdxD;
  logic [15:0]  gapQ, gapD;
  logic [ToW-1:0] toQ, toD;
  logic [1:0]   errCodeQ, errCodeD;
  logic [7:0]   rdDataQ, rdDataD;
  logic         rdValidQ, rdValidD;
  logic         attQ, attD;

  logic [7:0]   txData;
  logic         txValid;
  logic         txFire;
  logic [7:0]   expByte;
  logic         waitNow, waitNext;

  function automatic logic isWait(stateT s);
    return (s == StWaitSync) || (s == StWaitAck) || (s == StWaitHdr) || (s == StRecvData);
  endfunction

  // Tx byte/valid decode from the current frame position.
  always_comb begin
    txData  = '0;
    txValid = 1'b0;
    case (stateQ)
      StTxSync: begin
        txData  = 8'h55;
        txValid = 1'b1;
      end
      StTxHdr: begin
        txValid = 1'b1;
        case (hdrIdxQ)
          2'd0:    txData = {(opQ == OpWrite) ? 4'hC : 4'h8, addrQ[11:8]};
          2'd1:    txData = addrQ[7:0];
          2'd2:    txData = lenQ[7:0];
          default: txData = lenQ[15:8];
        endcase
      end
      StSendData: begin
        txData  = AWrData;
        txValid = AWrValid;
      end
      default: ;
    endcase
  end

  // Valid is masked by the clock enable so no handshake completes on a frozen cycle.
  assign ATxData  = txData;
  assign ATxValid = txValid & AClkHEn;
  assign txFire   = ATxValid & ATxReady;
  assign AWrReady = txFire & (stateQ == StSendData);

  assign expByte = (stateQ == StWaitSync) ? 8'h55 : 8'h00;

  // Next-state and command bookkeeping.
  always_comb begin
    stateD   = stateQ;
    opD      = opQ;
    addrD    = addrQ;
    lenD     = lenQ;
    remD     = remQ;
    hdrIdxD  = hdrIdxQ;
    gapD     = gapQ;
    errCodeD = errCodeQ;
    rdDataD  = rdDataQ;
    rdValidD = 1'b0;
    attD     = 1'b0;

    case (stateQ)
      StIdle: begin
        attD = ARxValid && (ARxData == 8'hAA);
        if (ACmdStart) begin
          opD      = ACmdOp;
          addrD    = ACmdAddr;
          lenD     = ACmdLen;
          remD     = ACmdLen;
          hdrIdxD  = 2'd0;
          errCodeD = 2'b00;
          unique case (ACmdOp)
            OpSync:          stateD = StTxSync;
            OpWrite, OpRead: stateD = StTxHdr;
            default: begin
              stateD   = StErr;
              errCodeD = ErrBadOp;
            end
          endcase
        end
      end

      StTxSync: begin
        if (txFire) stateD = StWaitSync;
      end

      StTxHdr: begin
        if (txFire) begin
          hdrIdxD = hdrIdxQ + 2'd1;
          if (hdrIdxQ == 2'd3) begin
            if (opQ == OpRead)     stateD = StWaitHdr;
            else if (lenQ == '0)   stateD = StWaitAck;
            else                   stateD = StSendData;
          end
        end
      end

      StSendData: begin
        if (txFire && (remQ != '0)) begin
          remD = remQ - 16'd1;
          if (CWrGap != 0) begin
            gapD   = 16'(CWrGap);
            stateD = StGap;
          end else if (remQ == 16'd1) begin
            stateD = StWaitAck;
          end
        end
      end

      StGap: begin
        if (gapQ <= 16'd1) begin
          stateD = (remQ == '0) ? StWaitAck : StSendData;
        end else begin
          gapD = gapQ - 16'd1;
        end
      end

      StWaitSync, StWaitAck, StWaitHdr: begin
        if (ARxValid) begin
          if (ARxData == expByte) begin
            stateD = ((stateQ == StWaitHdr) && (remQ != '0)) ? StRecvData : StDone;
          end else if (ARxData == 8'hAA) begin
            attD = 1'b1;
          end else begin
            stateD   = StErr;
            errCodeD = ErrBadResp;
          end
        end else if (toQ == '0) begin
          stateD   = StErr;
          errCodeD = ErrTimeout;
        end
      end

      StRecvData: begin
        if (ARxValid) begin
          rdDataD  = ARxData;
          rdValidD = 1'b1;
          if (remQ != '0) remD = remQ - 16'd1;
          if (remQ <= 16'd1) stateD = StDone;
        end else if (toQ == '0) begin
          stateD   = StErr;
          errCodeD = ErrTimeout;
        end
      end

      StDone:  stateD = StIdle;
      StErr:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  assign waitNow  = isWait(stateQ);
  assign waitNext = isWait(stateD);

  // Response timeout: reload on wait entry or any received byte, reload beats a tick.
  always_comb begin
    toD = toQ;
    if ((waitNext && (stateD != stateQ)) || ARxValid) begin
      toD = ToW'(CTimeOut);
    end else if (waitNow && ASync1K && (toQ != '0)) begin
      toD = toQ - ToW'(1);
    end
  end

  // State register with synchronous active-low reset and clock enable.
  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      stateQ   <= StIdle;
      opQ      <= '0;
      addrQ    <= '0;
      lenQ     <= '0;
      remQ     <= '0;
      hdrIdxQ  <= '0;
      gapQ     <= '0;
      toQ      <= '0;
      errCodeQ <= '0;
      rdDataQ  <= '0;
      rdValidQ <= 1'b0;
      attQ     <= 1'b0;
    end else if (AClkHEn) begin
      stateQ   <= stateD;
      opQ      <= opD;
      addrQ    <= addrD;
      lenQ     <= lenD;
      remQ     <= remD;
      hdrIdxQ  <= hdrIdxD;
      gapQ     <= gapD;
      toQ      <= toD;
      errCodeQ <= errCodeD;
      rdDataQ  <= rdDataD;
      rdValidQ <= rdValidD;
      attQ     <= attD;
    end
  end

  assign ABusy    = (stateQ != StIdle);
  assign ADone    = (stateQ == StDone);
  assign AErr     = (stateQ == StErr);
  assign AErrCode = errCodeQ;
  assign ARdData  = rdDataQ;
  assign ARdValid = rdValidQ;
  assign AAttSeen = attQ;

endmodule

// File: tb/tb_test_bridge_host.sv
// Directed + randomized bench for test_bridge_host with a frame-level reference model.
module tb_test_bridge_host;

  localparam int unsigned TimeOut = 3;
  localparam int unsigned WrGap   = 1;

  logic        AClkH = 1'b0;
  logic        AResetHN, AClkHEn, ASync1K, ACmdStart;
  logic [1:0]  ACmdOp;
  logic [11:0] ACmdAddr;
  logic [15:0] ACmdLen;
  logic [7:0]  AWrData;
  logic        AWrValid, AWrReady;
  logic [7:0]  ARdData;
  logic        ARdValid;
  logic [7:0]  ATxData;
  logic        ATxValid, ATxReady;
  logic [7:0]  ARxData;
  logic        ARxValid;
  logic        ABusy, ADone, AErr, AAttSeen;
  logic [1:0]  AErrCode;

  test_bridge_host #(.CTimeOut(TimeOut), .CWrGap(WrGap)) dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .ASync1K(ASync1K),
    .ACmdStart(ACmdStart), .ACmdOp(ACmdOp), .ACmdAddr(ACmdAddr), .ACmdLen(ACmdLen),
    .AWrData(AWrData), .AWrValid(AWrValid), .AWrReady(AWrReady),
    .ARdData(ARdData), .ARdValid(ARdValid),
    .ATxData(ATxData), .ATxValid(ATxValid), .ATxReady(ATxReady),
    .ARxData(ARxData), .ARxValid(ARxValid),
    .ABusy(ABusy), .ADone(ADone), .AErr(AErr), .AErrCode(AErrCode), .AAttSeen(AAttSeen)
  );

  always #5 AClkH = ~AClkH;

  int compared   = 0;
  int mismatched = 0;

  // Observation logs, written only by the monitor.
  logic [7:0] txLog[$];
  logic [7:0] rdLog[$];
  int wrCnt = 0, doneCnt = 0, errCnt = 0, attCnt = 0, bothCnt = 0;

  // Stimulus/model state, written only by the initial block.
  logic [7:0] payload[$];
  logic [7:0] expTx[$];
  logic [7:0] expRd[$];
  int txBase, rdBase, wrBase, doneBase, errBase, attBase;
  int readyMode = 0;

  always @(negedge AClkH) begin
    if (ATxValid && ATxReady) txLog.push_back(ATxData);
    if (ARdValid) rdLog.push_back(ARdData);
    if (AWrReady) wrCnt <= wrCnt + 1;
    if (ADone) doneCnt <= doneCnt + 1;
    if (AErr) errCnt <= errCnt + 1;
    if (AAttSeen) attCnt <= attCnt + 1;
    if (ADone && AErr) bothCnt <= bothCnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int idx;
    @(posedge AClkH);
    #1;
    case (readyMode)
      0:       ATxReady = 1'b1;
      1:       ATxReady = ~ATxReady;
      default: ATxReady = 1'($urandom_range(0, 1));
    endcase
    idx = wrCnt - wrBase;
    if (idx >= 0 && idx < payload.size()) begin
      AWrData  = payload[idx];
      AWrValid = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      AWrData  = 8'h00;
      AWrValid = 1'b0;
    end
  endtask

  // Frame model: what the link must carry for a command.
  task automatic buildTx(input logic [1:0] op, input logic [11:0] addr, input logic [15:0] len);
    expTx.delete();
    if (op == 2'b00) begin
      expTx.push_back(8'h55);
    end else if (op != 2'b11) begin
      expTx.push_back({(op == 2'b01) ? 4'hC : 4'h8, addr[11:8]});
      expTx.push_back(addr[7:0]);
      expTx.push_back(len[7:0]);
      expTx.push_back(len[15:8]);
      if (op == 2'b01) foreach (payload[i]) expTx.push_back(payload[i]);
    end
  endtask

  task automatic startCmd(input logic [1:0] op, input logic [11:0] addr, input logic [15:0] len);
    txBase   = txLog.size();
    rdBase   = rdLog.size();
    wrBase   = wrCnt;
    doneBase = doneCnt;
    errBase  = errCnt;
    attBase  = attCnt;
    expRd.delete();
    buildTx(op, addr, len);
    ACmdStart = 1'b1;
    ACmdOp    = op;
    ACmdAddr  = addr;
    ACmdLen   = len;
    step();
    ACmdStart = 1'b0;
  endtask

  task automatic waitTx(input string tag);
    for (int i = 0; i < 400 && (txLog.size() - txBase) < expTx.size(); i++) step();
    check({tag, "_txcount"}, 32'(txLog.size() - txBase), 32'(expTx.size()));
    step();
    step();
  endtask

  task automatic checkTx(input string tag);
    logic [7:0] got;
    foreach (expTx[i]) begin
      got = (txBase + i < txLog.size()) ? txLog[txBase + i] : 8'hxx;
      check($sformatf("%s_tx%0d", tag, i), 32'(got), 32'(expTx[i]));
    end
  endtask

  task automatic checkRd(input string tag);
    logic [7:0] got;
    check({tag, "_rdcount"}, 32'(rdLog.size() - rdBase), 32'(expRd.size()));
    foreach (expRd[i]) begin
      got = (rdBase + i < rdLog.size()) ? rdLog[rdBase + i] : 8'hxx;
      check($sformatf("%s_rd%0d", tag, i), 32'(got), 32'(expRd[i]));
    end
  endtask

  task automatic rx(input logic [7:0] b);
    ARxValid = 1'b1;
    ARxData  = b;
    step();
    ARxValid = 1'b0;
    ARxData  = 8'h00;
  endtask

  task automatic tick();
    ASync1K = 1'b1;
    step();
    ASync1K = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 400 && ABusy; i++) step();
    check({tag, "_idle"}, 32'(ABusy), 32'd0);
    step();
  endtask

  task automatic checkStatus(input string tag, input int dn, input int er, input int at,
                             input logic [1:0] code);
    check({tag, "_done"}, 32'(doneCnt - doneBase), 32'(dn));
    check({tag, "_err"},  32'(errCnt - errBase),   32'(er));
    check({tag, "_att"},  32'(attCnt - attBase),   32'(at));
    check({tag, "_code"}, 32'(AErrCode),           32'(code));
  endtask

  function automatic logic [31:0] allOut();
    return 32'({ABusy, ATxValid, ATxData, ARdData, ARdValid, ADone, AErr, AErrCode,
                AAttSeen, AWrReady});
  endfunction

  initial begin
    logic [1:0]  op;
    logic [11:0] addr;
    logic [15:0] len;
    logic [7:0]  b;
    int          nAtt;

    AResetHN = 1'b0; AClkHEn = 1'b1; ASync1K = 1'b0; ACmdStart = 1'b0;
    ACmdOp = '0; ACmdAddr = '0; ACmdLen = '0; AWrData = '0; AWrValid = 1'b0;
    ATxReady = 1'b1; ARxData = '0; ARxValid = 1'b0;
    txBase = 0; rdBase = 0; wrBase = 0; doneBase = 0; errBase = 0; attBase = 0;

    // Reset state.
    step(); step(); step();
    check("reset_outputs", allOut(), 32'd0);
    AResetHN = 1'b1;
    step();
    check("reset_idle_busy", 32'(ABusy), 32'd0);

    // Sync.
    readyMode = 0;
    startCmd(2'b00, 12'h000, 16'd0);
    check("sync_busy", 32'(ABusy), 32'd1);
    waitTx("sync");
    checkTx("sync");
    rx(8'h55);
    waitIdle("sync");
    checkStatus("sync", 1, 0, 0, 2'b00);

    // Write 0x123 len 3 with toggling ready.
    readyMode = 1;
    payload = '{8'hA1, 8'hB2, 8'hC3};
    startCmd(2'b01, 12'h123, 16'd3);
    waitTx("wr");
    checkTx("wr");
    check("wr_wrready", 32'(wrCnt - wrBase), 32'd3);
    rx(8'h00);
    waitIdle("wr");
    checkStatus("wr", 1, 0, 0, 2'b00);
    payload.delete();

    // Read 0x700 len 2 with attention byte before the header ack.
    readyMode = 0;
    startCmd(2'b10, 12'h700, 16'd2);
    waitTx("rd");
    checkTx("rd");
    rx(8'hAA);
    rx(8'h00);
    rx(8'h11);
    step();
    rx(8'h22);
    expRd = '{8'h11, 8'h22};
    waitIdle("rd");
    checkRd("rd");
    checkStatus("rd", 1, 0, 1, 2'b00);

    // Read len 0 completes straight from the header ack.
    startCmd(2'b10, 12'h3C5, 16'd0);
    waitTx("rd0");
    checkTx("rd0");
    rx(8'h00);
    waitIdle("rd0");
    checkRd("rd0");
    checkStatus("rd0", 1, 0, 0, 2'b00);

    // Read len 0 with a bad header byte.
    startCmd(2'b10, 12'h3C5, 16'd0);
    waitTx("rd0bad");
    rx(8'h5A);
    waitIdle("rd0bad");
    checkStatus("rd0bad", 0, 1, 0, 2'b10);
    step(); step();
    check("errcode_held", 32'(AErrCode), 32'd2);

    // Start while busy is ignored.
    startCmd(2'b00, 12'h000, 16'd0);
    check("busy_errcode_clr", 32'(AErrCode), 32'd0);
    waitTx("busyign");
    ACmdStart = 1'b1; ACmdOp = 2'b01; ACmdAddr = 12'hFFF; ACmdLen = 16'd1;
    step();
    ACmdStart = 1'b0;
    rx(8'h55);
    waitIdle("busyign");
    step(); step(); step();
    check("busyign_nobusy", 32'(ABusy), 32'd0);
    check("busyign_txcount", 32'(txLog.size() - txBase), 32'd1);
    checkStatus("busyign", 1, 0, 0, 2'b00);

    // Reserved op.
    startCmd(2'b11, 12'h055, 16'd7);
    check("resop_err_now", 32'(AErr), 32'd1);
    waitIdle("resop");
    check("resop_txcount", 32'(txLog.size() - txBase), 32'd0);
    checkStatus("resop", 0, 1, 0, 2'b11);

    // Timeout with reload-beats-tick.
    startCmd(2'b01, 12'h246, 16'd0);
    waitTx("to");
    checkTx("to");
    tick();
    tick();
    ARxValid = 1'b1; ARxData = 8'hAA; ASync1K = 1'b1;
    step();
    ARxValid = 1'b0; ARxData = 8'h00; ASync1K = 1'b0;
    tick();
    tick();
    step();
    step();
    check("to_reload_busy", 32'(ABusy), 32'd1);
    check("to_reload_noerr", 32'(errCnt - errBase), 32'd0);
    tick();
    waitIdle("to");
    checkStatus("to", 0, 1, 1, 2'b01);

    // Reset during SendData.
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    startCmd(2'b01, 12'h9AB, 16'd4);
    for (int i = 0; i < 200 && (wrCnt - wrBase) < 1; i++) step();
    check("rstmid_insend", 32'(wrCnt - wrBase), 32'd1);
    AResetHN = 1'b0;
    step();
    check("rstmid_outputs", allOut(), 32'd0);
    AResetHN = 1'b1;
    payload.delete();
    step(); step();
    check("rstmid_done", 32'(doneCnt - doneBase), 32'd0);
    check("rstmid_err", 32'(errCnt - errBase), 32'd0);
    startCmd(2'b00, 12'h000, 16'd0);
    waitTx("rstsync");
    checkTx("rstsync");
    rx(8'h55);
    waitIdle("rstsync");
    checkStatus("rstsync", 1, 0, 0, 2'b00);

    // Randomized commands against the frame model.
    for (int it = 0; it < 10; it++) begin
      op        = 2'($urandom_range(0, 2));
      addr      = 12'($urandom);
      len       = 16'($urandom_range(0, 5));
      readyMode = $urandom_range(0, 2);
      payload.delete();
      if (op == 2'b01) for (int k = 0; k < len; k++) payload.push_back(8'($urandom));
      startCmd(op, addr, (op == 2'b00) ? 16'd0 : len);
      waitTx($sformatf("rnd%0d", it));
      checkTx($sformatf("rnd%0d", it));
      nAtt = $urandom_range(0, 2);
      for (int k = 0; k < nAtt; k++) rx(8'hAA);
      rx((op == 2'b00) ? 8'h55 : 8'h00);
      if (op == 2'b10) begin
        for (int k = 0; k < len; k++) begin
          b = ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom);
          expRd.push_back(b);
          for (int g = $urandom_range(0, 2); g > 0; g--) step();
          rx(b);
        end
      end
      waitIdle($sformatf("rnd%0d", it));
      checkRd($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_wr", it), 32'(wrCnt - wrBase),
            (op == 2'b01) ? 32'(len) : 32'd0);
      checkStatus($sformatf("rnd%0d", it), 1, 0, nAtt, 2'b00);
    end

    check("done_err_exclusive", 32'(bothCnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
